// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns a typed request into a 32-bit word behind one
// output register stage, tracking the memory word address and an emitted-word count.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_type,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [7:0]  out_addr,
    output logic        illegal,
    output logic [7:0]  word_cnt
);

    localparam logic [4:0] TypeSub   = 5'd0;
    localparam logic [4:0] TypeAdd   = 5'd1;
    localparam logic [4:0] TypeOr    = 5'd2;
    localparam logic [4:0] TypeAnd   = 5'd3;
    localparam logic [4:0] TypeSra   = 5'd4;
    localparam logic [4:0] TypeSrl   = 5'd5;
    localparam logic [4:0] TypeSll   = 5'd6;
    localparam logic [4:0] TypeJ     = 5'd7;
    localparam logic [4:0] TypeOri   = 5'd8;
    localparam logic [4:0] TypeAndi  = 5'd9;
    localparam logic [4:0] TypeAddi  = 5'd10;
    localparam logic [4:0] TypeBne   = 5'd11;
    localparam logic [4:0] TypeBeq   = 5'd12;
    localparam logic [4:0] TypeSw    = 5'd13;
    localparam logic [4:0] TypeLw    = 5'd14;
    localparam logic [4:0] TypeJal   = 5'd15;
    localparam logic [4:0] TypeJr    = 5'd16;
    localparam logic [4:0] TypeSltiu = 5'd17;
    localparam logic [4:0] TypeSlti  = 5'd18;
    localparam logic [4:0] TypeLui   = 5'd19;
    localparam logic [4:0] TypeXori  = 5'd20;
    localparam logic [4:0] TypeAddiu = 5'd21;
    localparam logic [4:0] TypeSrav  = 5'd22;
    localparam logic [4:0] TypeSrlv  = 5'd23;
    localparam logic [4:0] TypeSllv  = 5'd24;
    localparam logic [4:0] TypeSltu  = 5'd25;
    localparam logic [4:0] TypeSlt   = 5'd26;
    localparam logic [4:0] TypeNor   = 5'd27;
    localparam logic [4:0] TypeXor   = 5'd28;
    localparam logic [4:0] TypeSubu  = 5'd29;
    localparam logic [4:0] TypeAddu  = 5'd30;

    logic        legal_s;
    logic        rType_s;
    logic        jType_s;
    logic [5:0]  opcode_s;
    logic [5:0]  func_s;
    logic        zeroRs_s;
    logic        zeroRtRd_s;
    logic        keepShamt_s;
    logic [4:0]  rsField_s;
    logic [4:0]  rtField_s;
    logic [4:0]  rdField_s;
    logic [4:0]  shamtField_s;
    logic [31:0] encWord_s;
    logic        accept_s;
    logic        load_s;
    logic        xfer_s;

    logic        outValid_r;
    logic [31:0] outWord_r;
    logic [7:0]  outAddr_r;
    logic [7:0]  wordCnt_r;
    logic        illegal_r;

    // Decode the type code into format, opcode/func and field-forcing controls
    always_comb begin
        legal_s     = 1'b1;
        rType_s     = 1'b0;
        jType_s     = 1'b0;
        opcode_s    = 6'b000000;
        func_s      = 6'b000000;
        zeroRs_s    = 1'b0;
        zeroRtRd_s  = 1'b0;
        keepShamt_s = 1'b0;
        case (in_type)
            TypeSub:   begin rType_s = 1'b1; func_s = 6'b100010; end
            TypeAdd:   begin rType_s = 1'b1; func_s = 6'b100000; end
            TypeOr:    begin rType_s = 1'b1; func_s = 6'b100101; end
            TypeAnd:   begin rType_s = 1'b1; func_s = 6'b100100; end
            TypeSra:   begin rType_s = 1'b1; func_s = 6'b000011; zeroRs_s = 1'b1; keepShamt_s = 1'b1; end
            TypeSrl:   begin rType_s = 1'b1; func_s = 6'b000010; zeroRs_s = 1'b1; keepShamt_s = 1'b1; end
            TypeSll:   begin rType_s = 1'b1; func_s = 6'b000000; zeroRs_s = 1'b1; keepShamt_s = 1'b1; end
            TypeJr:    begin rType_s = 1'b1; func_s = 6'b001000; zeroRtRd_s = 1'b1; end
            TypeSrav:  begin rType_s = 1'b1; func_s = 6'b000111; end
            TypeSrlv:  begin rType_s = 1'b1; func_s = 6'b000110; end
            TypeSllv:  begin rType_s = 1'b1; func_s = 6'b000100; end
            TypeSltu:  begin rType_s = 1'b1; func_s = 6'b101011; end
            TypeSlt:   begin rType_s = 1'b1; func_s = 6'b101010; end
            TypeNor:   begin rType_s = 1'b1; func_s = 6'b100111; end
            TypeXor:   begin rType_s = 1'b1; func_s = 6'b100110; end
            TypeSubu:  begin rType_s = 1'b1; func_s = 6'b100011; end
            TypeAddu:  begin rType_s = 1'b1; func_s = 6'b100001; end
            TypeJ:     begin jType_s = 1'b1; opcode_s = 6'b000010; end
            TypeJal:   begin jType_s = 1'b1; opcode_s = 6'b000011; end
            TypeOri:   opcode_s = 6'b001101;
            TypeAndi:  opcode_s = 6'b001100;
            TypeAddi:  opcode_s = 6'b001000;
            TypeBne:   opcode_s = 6'b000101;
            TypeBeq:   opcode_s = 6'b000100;
            TypeSw:    opcode_s = 6'b101011;
            TypeLw:    opcode_s = 6'b100011;
            TypeSltiu: opcode_s = 6'b001011;
            TypeSlti:  opcode_s = 6'b001010;
            TypeLui:   begin opcode_s = 6'b001111; zeroRs_s = 1'b1; end
            TypeXori:  opcode_s = 6'b001110;
            TypeAddiu: opcode_s = 6'b001001;
            default:   legal_s = 1'b0;
        endcase
    end

    // Apply field forcing and assemble the instruction word for its format
    always_comb begin
        rsField_s    = zeroRs_s    ? 5'd0 : in_rs;
        rtField_s    = zeroRtRd_s  ? 5'd0 : in_rt;
        rdField_s    = zeroRtRd_s  ? 5'd0 : in_rd;
        shamtField_s = keepShamt_s ? in_shamt : 5'd0;
        if (jType_s) begin
            encWord_s = {opcode_s, in_target};
        end else if (rType_s) begin
            encWord_s = {6'b000000, rsField_s, rtField_s, rdField_s, shamtField_s, func_s};
        end else begin
            encWord_s = {opcode_s, rsField_s, rtField_s, in_imm};
        end
    end

    // clr blocks acceptance so a request can never slip in alongside the clear
    assign in_ready = ~clr & (~outValid_r | out_ready);
    assign accept_s = in_valid & in_ready;
    assign load_s   = accept_s & legal_s;
    assign xfer_s   = outValid_r & out_ready;

    // Output stage: word/valid handshake, address per transfer, saturating count, illegal pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_r <= 1'b0;
            outWord_r  <= 32'd0;
            outAddr_r  <= 8'd0;
            wordCnt_r  <= 8'd0;
            illegal_r  <= 1'b0;
        end else if (clr) begin
            outValid_r <= 1'b0;
            outWord_r  <= 32'd0;
            outAddr_r  <= 8'd0;
            wordCnt_r  <= 8'd0;
            illegal_r  <= 1'b0;
        end else begin
            illegal_r <= accept_s & ~legal_s;
            if (load_s) begin
                outWord_r  <= encWord_s;
                outValid_r <= 1'b1;
            end else if (xfer_s) begin
                outValid_r <= 1'b0;
            end
            if (xfer_s) begin
                outAddr_r <= outAddr_r + 8'd1;
                if (wordCnt_r != 8'd255) begin
                    wordCnt_r <= wordCnt_r + 8'd1;
                end
            end
        end
    end

    assign out_valid = outValid_r;
    assign out_word  = outWord_r;
    assign out_addr  = outAddr_r;
    assign word_cnt  = wordCnt_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed encoding vectors, hand-written handshake/reset
// sequences, then randomized traffic against a table-based scoreboard.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [4:0]  in_type, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic [31:0] out_word;
    logic [7:0]  out_addr, word_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .illegal(illegal), .word_cnt(word_cnt)
    );

    // Reference encoding tables indexed by type code: class 0=R, 1=I, 2=J; code = func or opcode
    int refCls  [0:30] = '{0,0,0,0,0,0,0,2,1,1,1,1,1,1,1,2,0,1,1,1,1,1,0,0,0,0,0,0,0,0,0};
    int refCode [0:30] = '{34,32,37,36,3,2,0,2,13,12,8,5,4,43,35,3,8,11,10,15,14,9,7,6,4,43,42,39,38,35,33};

    function automatic logic [31:0] refEncode(input int typ, input int rs, input int rt, input int rd,
                                              input int sh, input int imm, input int tgt);
        int unsigned r = rs, t = rt, d = rd, s = sh, c = refCode[typ];
        if (refCls[typ] == 2) return 32'(c * 67108864 + tgt);
        if (refCls[typ] == 1) begin
            if (typ == 19) r = 0;
            return 32'(c * 67108864 + r * 2097152 + t * 65536 + imm);
        end
        if (typ == 4 || typ == 5 || typ == 6) r = 0;
        else s = 0;
        if (typ == 16) begin t = 0; d = 0; end
        return 32'(r * 2097152 + t * 65536 + d * 2048 + s * 64 + c);
    endfunction

    typedef struct {
        logic [4:0]  typ, rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] typ, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt);
        in_valid = v; in_type = typ; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt;
    endtask

    task automatic doReset();
        rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_word", out_word, 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] q[$];
    int          xfers;
    logic        illExp, expValid, expReady, acc;

    initial begin
        vecs[0]  = '{5'd1,  5'd1,  5'd2,  5'd3, 5'd9,  16'h0000, 26'h0000000, 32'h00221820};
        vecs[1]  = '{5'd14, 5'd9,  5'd8,  5'd0, 5'd0,  16'h0004, 26'h0000000, 32'h8D280004};
        vecs[2]  = '{5'd19, 5'd7,  5'd5,  5'd0, 5'd0,  16'h1234, 26'h0000000, 32'h3C051234};
        vecs[3]  = '{5'd6,  5'd7,  5'd1,  5'd2, 5'd4,  16'h0000, 26'h0000000, 32'h00011100};
        vecs[4]  = '{5'd7,  5'd3,  5'd3,  5'd3, 5'd3,  16'hFFFF, 26'h0000010, 32'h08000010};
        vecs[5]  = '{5'd16, 5'd31, 5'd5,  5'd6, 5'd7,  16'h0000, 26'h0000000, 32'h03E00008};
        vecs[6]  = '{5'd15, 5'd0,  5'd0,  5'd0, 5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
        vecs[7]  = '{5'd4,  5'd3,  5'd4,  5'd5, 5'd31, 16'h0000, 26'h0000000, 32'h00042FC3};
        vecs[8]  = '{5'd12, 5'd1,  5'd2,  5'd0, 5'd0,  16'hFFFF, 26'h0000000, 32'h1022FFFF};
        vecs[9]  = '{5'd27, 5'd4,  5'd5,  5'd6, 5'd3,  16'h0000, 26'h0000000, 32'h00853027};
        vecs[10] = '{5'd13, 5'd29, 5'd31, 5'd0, 5'd0,  16'h8000, 26'h0000000, 32'hAFBF8000};
        vecs[11] = '{5'd17, 5'd2,  5'd3,  5'd0, 5'd0,  16'h00FF, 26'h0000000, 32'h2C4300FF};

        doReset();

        // Fixed encoding vectors, one word every other cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive(1'b1, vecs[i].typ, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
            @(negedge clk);
            drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_word", i), out_word, vecs[i].exp);
            check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(i));
        end

        // Back-to-back lw then lui
        doReset();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 5'd14, 5'd9, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0);
        @(negedge clk);
        drive(1'b1, 5'd19, 5'd7, 5'd5, 5'd0, 5'd0, 16'h1234, 26'd0);
        #1;
        check("b2b_w0", out_word, 32'h8D280004);
        check("b2b_a0", 32'(out_addr), 32'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #1;
        check("b2b_valid1", 32'(out_valid), 32'd1);
        check("b2b_w1", out_word, 32'h3C051234);
        check("b2b_a1", 32'(out_addr), 32'd1);

        // sll held under backpressure for three cycles
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 5'd6, 5'd7, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0);
        #1;
        check("stall_rdy_empty", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_word", out_word, 32'h00011100);
            check("stall_addr", 32'(out_addr), 32'd2);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_cnt", 32'(word_cnt), 32'd3);
        check("release_addr", 32'(out_addr), 32'd3);

        // Asynchronous reset while a word is stalled
        drive(1'b1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #1;
        check("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_word", out_word, 32'd0);
        check("arst_addr", 32'(out_addr), 32'd0);
        check("arst_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // j after reset lands at address 0, then an illegal code
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000010);
        @(negedge clk);
        drive(1'b1, 5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'd0);
        #1;
        check("j_word", out_word, 32'h08000010);
        check("j_addr", 32'(out_addr), 32'd0);
        check("j_ill_before", 32'(illegal), 32'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #1;
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd0);
        check("ill_addr", 32'(out_addr), 32'd1);
        check("ill_cnt", 32'(word_cnt), 32'd1);
        @(negedge clk);
        #1;
        check("ill_one_cycle", 32'(illegal), 32'd0);
        check("ill_addr_after", 32'(out_addr), 32'd1);
        check("ill_cnt_after", 32'(word_cnt), 32'd1);

        // Stream 257 words: address wrap and count saturation, then clear
        doReset();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 5'd30, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        for (int k = 0; k <= 256; k++) begin
            @(negedge clk);
            if (k == 256) drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
            #1;
            if (k == 255) check("wrap_addr255", 32'(out_addr), 32'd255);
            if (k == 256) begin
                check("wrap_addr0", 32'(out_addr), 32'd0);
                check("wrap_cnt_sat", 32'(word_cnt), 32'd255);
                check("wrap_word", out_word, 32'h00221821);
            end
        end
        @(negedge clk);
        clr = 1'b1;
        drive(1'b1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        #1;
        check("clr_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_addr", 32'(out_addr), 32'd0);
        check("clr_cnt", 32'(word_cnt), 32'd0);
        check("clr_illegal", 32'(illegal), 32'd0);
        clr = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);

        // Randomized traffic against the scoreboard
        doReset();
        q.delete();
        xfers = 0;
        illExp = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            clr       = ($urandom_range(699) == 0);
            in_type   = ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(30));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_shamt  = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            #1;
            expValid = (q.size() != 0);
            expReady = !clr && (!expValid || out_ready);
            check("rnd_valid", 32'(out_valid), 32'(expValid));
            check("rnd_in_ready", 32'(in_ready), 32'(expReady));
            if (expValid) check("rnd_word", out_word, q[0]);
            check("rnd_addr", 32'(out_addr), 32'(xfers % 256));
            check("rnd_cnt", 32'(word_cnt), 32'((xfers > 255) ? 255 : xfers));
            check("rnd_illegal", 32'(illegal), 32'(illExp));
            if (clr) begin
                q.delete();
                xfers = 0;
                illExp = 1'b0;
            end else begin
                acc = in_valid && expReady;
                if (expValid && out_ready) begin
                    void'(q.pop_front());
                    xfers++;
                end
                illExp = acc && (in_type == 5'd31);
                if (acc && in_type != 5'd31)
                    q.push_back(refEncode(int'(in_type), int'(in_rs), int'(in_rt), int'(in_rd),
                                          int'(in_shamt), int'(in_imm), int'(in_target)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  request valid.
REQ-004 in_ready  output  1  request accepted when in_valid & in_ready at a clock edge.
REQ-005 in_type  input  5  instruction type code, table in REQ-014; 31 is illegal.
REQ-006 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift-amount fields.
REQ-007 in_imm  input  16  immediate for I-type.
REQ-008 in_target  input  26  jump target for J-type.
REQ-009 clr  input  1  synchronous clear: address to 0, count to 0, pending word dropped; overrides all else.
REQ-010 out_valid  output  1  encoded word available.
REQ-011 out_ready  input  1  consumer (instruction-memory writer) accepts when out_valid & out_ready.
REQ-012 out_word  output  32  encoded MIPS instruction; out_addr  output  8  word address.
REQ-013 illegal  output  1  one-cycle pulse on illegal code; word_cnt  output  8  emitted-word count.

Function
REQ-014 Codes: 0 sub, 1 add, 2 or, 3 and, 4 sra, 5 srl, 6 sll, 7 j, 8 ori, 9 andi, 10 addi, 11 bne, 12 beq, 13 sw, 14 lw, 15 jal, 16 jr, 17 sltiu, 18 slti, 19 lui, 20 xori, 21 addiu, 22 srav, 23 srlv, 24 sllv, 25 sltu, 26 slt, 27 nor, 28 xor, 29 subu, 30 addu.
REQ-015 R-type: op 000000, word = {op, rs, rt, rd, shamt, func}; funcs add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111, jr 001000.
REQ-016 Field forcing: sll/srl/sra force rs=0; jr forces rt=rd=shamt=0; all other R-type force shamt=0.
REQ-017 I-type word = {op, rs, rt, imm}; ops lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lui 001111; lui forces rs=0.
REQ-018 J-type word = {op, target}; j 000010, jal 000011.
REQ-019 One output register stage; accepted legal request appears on out_word with out_valid=1 the next cycle (latency 1).
REQ-020 in_ready = ~out_valid | out_ready, combinational; back-to-back throughput one word per cycle while out_ready=1.
REQ-021 out_word, out_addr held stable while out_valid=1 and out_ready=0.
REQ-022 out_addr = address of current word; increments by 1 per output transfer, wraps 255 -> 0.
REQ-023 word_cnt increments per output transfer, saturates at 255.
REQ-024 Accepted illegal code (31): no word produced, out_valid unchanged by it, illegal=1 next cycle for exactly one cycle; out_addr, word_cnt unchanged.
REQ-025 Simultaneous output transfer and new acceptance: old word retires, new word loads same edge, out_valid stays 1.
REQ-026 clr=1: out_valid->0, out_addr->0, word_cnt->0, illegal->0 next cycle; in_ready=0 while clr=1; no request accepted.

Reset
REQ-027 rst_n=0 immediately forces out_valid=0, out_word=0, out_addr=0, word_cnt=0, illegal=0, regardless of clock.
REQ-028 Reset mid-transfer discards pending word; first post-reset word gets out_addr 0.

Verification
REQ-029 add type 1, rs=1 rt=2 rd=3 shamt=9 -> out_word 0x00221820, out_addr 0, one cycle later.
REQ-030 lw type 14, rs=9 rt=8 imm=0x0004 then lui type 19, rs=7 rt=5 imm=0x1234 back-to-back, out_ready=1 -> 0x8D280004 @addr 0, 0x3C051234 @addr 1, consecutive cycles.
REQ-031 sll type 6, rs=7 rt=1 rd=2 shamt=4 with out_ready=0 for 3 cycles -> 0x00011100 held, in_ready=0, one transfer on release.
REQ-032 j type 7, target 0x0000010 -> 0x08000010; type 31 next -> illegal pulse one cycle, addr/count unchanged.
REQ-033 256 legal words streamed -> out_addr wraps to 0 on 257th word, word_cnt stuck at 255; then clr -> all zero.
REQ-034 rst_n low while out_valid=1 and out_ready=0 -> outputs zero asynchronously; next word at addr 0.
